// File: rtl/lut_pkg.sv
// rtl/lut_pkg.sv - shared types and widths for the lookup-table arbiter
package lut_pkg;

  localparam int KEY_W = 4;
  localparam int VAL_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP
  } lut_state_t;

  typedef logic [KEY_W-1:0] lut_key_t;
  typedef logic [VAL_W-1:0] lut_val_t;

endpackage

// File: rtl/lookup.sv
// rtl/lookup.sv - constant 16-entry key-to-value table
module lookup
  import lut_pkg::*;
(
  input  lut_key_t key_i,
  output lut_val_t value_o
);

  // Fully decoded table: low keys map to odd constants, every other key to all-ones
  always_comb begin
    value_o = 8'hFF;
    case (key_i)
      4'h0:    value_o = 8'h01;
      4'h1:    value_o = 8'h03;
      4'h2:    value_o = 8'h05;
      4'h3:    value_o = 8'h07;
      default: value_o = 8'hFF;
    endcase
  end

endmodule

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin one-hot grant
module rr_grant #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan upward from the pointer, wrapping, and grant the first active request
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut_arbiter.sv
// rtl/lut_arbiter.sv - round-robin arbiter sharing one lookup table among requesters
module lut_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int KEY_W   = 4,
  parameter int VAL_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*KEY_W-1:0] req_key,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [VAL_W-1:0]         rsp_value,
  output logic [ID_W-1:0]          rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy
);

  import lut_pkg::*;

  lut_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [VAL_W-1:0] rsp_value_q, rsp_value_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    win_id;
  logic [KEY_W-1:0]   win_key;
  logic [ID_W-1:0]    next_ptr;
  lut_val_t           table_val;

  rr_grant #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_rr_grant (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  lookup u_lookup (
    .key_i   (key_q),
    .value_o (table_val)
  );

  // Encode the one-hot grant into the winner's ID and select its key
  always_comb begin
    win_id  = '0;
    win_key = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_id  = ID_W'(i);
        win_key = req_key[i*KEY_W +: KEY_W];
      end
    end
  end

  assign next_ptr = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  // Next-state and handshake logic; the pointer moves only when a grant is taken
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    key_d       = key_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_value_d = rsp_value_q;
    rsp_id_d    = rsp_id_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|grant) begin
          key_d    = win_key;
          id_d     = win_id;
          rr_ptr_d = next_ptr;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        rsp_value_d = table_val;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      key_q       <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_value_q <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      key_q       <= key_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_value_q <= rsp_value_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_value = rsp_value_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lut_arbiter.sv
// tb/tb_lut_arbiter.sv - self-checking bench for lut_arbiter against a transaction model
module tb_lut_arbiter;

  localparam int N  = 3;
  localparam int KW = 4;
  localparam int VW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*KW-1:0] req_key;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [VW-1:0]   rsp_value;
  logic [IW-1:0]   rsp_id;
  logic            rsp_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int val;
  } rsp_t;

  rsp_t exp_q[$];
  int   grants[$];
  int   m_ptr;
  int   m_stage;   // 0: free, 1: lookup pending, 2: response offered

  lut_arbiter #(
    .NUM_REQ (N),
    .KEY_W   (KW),
    .VAL_W   (VW),
    .ID_W    (IW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_key   (req_key),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_value (rsp_value),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tbl(input int k);
    return (k < 4) ? (2 * k + 1) : 255;
  endfunction

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int r;
      r = (m_ptr + i) % N;
      if (req_valid[r]) return r;
    end
    return -1;
  endfunction

  task automatic set_req(input int idx, input logic v, input logic [KW-1:0] k);
    req_valid[idx]        = v;
    req_key[idx*KW +: KW] = k;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_stage = 0;
    exp_q.delete();
  endtask

  // One clock: check outputs against the model, then advance the model at the edge
  task automatic cycle();
    int         g;
    logic [N-1:0] exp_rdy;
    #1;
    g = (m_stage == 0) ? pick() : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("busy", 32'(busy), 32'(m_stage != 0));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
    if (m_stage == 2 && exp_q.size() > 0) begin
      check_eq("rsp_value", 32'(rsp_value), exp_q[0].val);
      check_eq("rsp_id", 32'(rsp_id), exp_q[0].id);
    end
    @(posedge clk);
    case (m_stage)
      0: if (g >= 0) begin
        rsp_t r;
        r.id  = g;
        r.val = tbl(int'(req_key[g*KW +: KW]));
        exp_q.push_back(r);
        grants.push_back(g);
        m_ptr   = (g + 1) % N;
        m_stage = 1;
      end
      1: m_stage = 2;
      default: if (rsp_ready) begin
        void'(exp_q.pop_front());
        m_stage = 0;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_key   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_value", 32'(rsp_value), 0);
    check_eq("rst_rsp_id", 32'(rsp_id), 0);
    check_eq("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int budget;

    // Reset and a single request
    do_reset();
    set_req(0, 1'b1, 4'h2);
    rsp_ready = 1'b1;
    #1 check_eq("t1_ready", 32'(req_ready), 32'h1);
    cycle();
    set_req(0, 1'b0, 4'h2);
    cycle();
    check_eq("t1_rsp_valid", 32'(rsp_valid), 1);
    check_eq("t1_rsp_value", 32'(rsp_value), 32'h05);
    check_eq("t1_rsp_id", 32'(rsp_id), 0);
    cycle();
    check_eq("t1_rsp_drop", 32'(rsp_valid), 0);

    // Simultaneous requests from a fresh pointer
    do_reset();
    grants.delete();
    set_req(0, 1'b1, 4'h0);
    set_req(1, 1'b1, 4'h3);
    rsp_ready = 1'b1;
    budget = 0;
    while (grants.size() < 3 && budget < 30) begin
      cycle();
      budget++;
    end
    check_eq("t2_ngrants", grants.size(), 3);
    if (grants.size() >= 3) begin
      check_eq("t2_g0", grants[0], 0);
      check_eq("t2_g1", grants[1], 1);
      check_eq("t2_g2", grants[2], 0);
    end
    req_valid = '0;
    while (m_stage != 0 && budget < 40) begin
      cycle();
      budget++;
    end

    // Backpressure holds the response stable
    set_req(0, 1'b1, 4'h1);
    rsp_ready = 1'b0;
    cycle();
    req_valid = '0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_value", 32'(rsp_value), 32'h03);
      check_eq("t3_id", 32'(rsp_id), 0);
      check_eq("t3_ready", 32'(req_ready), 0);
      check_eq("t3_busy", 32'(busy), 1);
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    check_eq("t3_done", 32'(busy), 0);

    // Upper keys all map to all-ones
    for (int k = 4; k < 16; k++) begin
      set_req(1, 1'b1, 4'(k));
      cycle();
      req_valid = '0;
      cycle();
      check_eq("t4_value", 32'(rsp_value), 32'hFF);
      check_eq("t4_id", 32'(rsp_id), 1);
      cycle();
    end

    // Asynchronous reset while a lookup is in flight
    do_reset();
    set_req(0, 1'b1, 4'h5);
    cycle();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rsp_valid", 32'(rsp_valid), 0);
    check_eq("t5_busy", 32'(busy), 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("t5_no_rsp", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    grants.delete();
    set_req(0, 1'b1, 4'h0);
    set_req(1, 1'b1, 4'h1);
    rsp_ready = 1'b1;
    cycle();
    check_eq("t5_ngrants", grants.size(), 1);
    if (grants.size() > 0) check_eq("t5_winner", grants[0], 0);
    req_valid = '0;
    cycle();
    cycle();

    // Fairness with all three requesters active
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'($urandom_range(0, 15)));
    rsp_ready = 1'b1;
    budget = 0;
    while (grants.size() < 9 && budget < 60) begin
      cycle();
      budget++;
    end
    check_eq("t6_ngrants", grants.size(), 9);
    for (int i = 0; i < grants.size() && i < 9; i++) check_eq("t6_order", grants[i], i % N);

    // Random traffic against the model
    for (int it = 0; it < 400; it++) begin
      req_valid = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) req_key = 12'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_arbiter.md
Name: lut_arbiter

Overview:
- Shares the single 16-entry, 4-bit-key / 8-bit-value constant lookup table between NUM_REQ requesters, e.g. the decode-stage immediate expander and the branch-target unit.
- Arbitrates round-robin, runs one lookup at a time, and returns a registered value with the winner's ID.
- Holds each response until the consumer accepts it.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- KEY_W, 4, key width.
- VAL_W, 8, value width.
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_key  in  NUM_REQ*KEY_W  packed keys; requester i uses bits [i*KEY_W +: KEY_W].
- req_ready  out  NUM_REQ  one-hot grant / accept.
- rsp_valid  out  1  response available.
- rsp_value  out  VAL_W  looked-up value.
- rsp_id  out  ID_W  requester that owns the response.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_value=0, rsp_id=0, key_q=0, id_q=0. Any transaction in flight is dropped with no response.
- Once reset is released, the next rising edge behaves as IDLE.
- FSM states are IDLE, LOOKUP, RESP.
- IDLE:
  - req_ready is combinational and one-hot. It goes to the first requester with req_valid=1, searching upward from rr_ptr and wrapping modulo NUM_REQ.
  - req_ready is all-zero when no requester is valid.
  - On a handshake (req_valid[g] & req_ready[g]): key_q<=req_key[g], id_q<=g, rr_ptr<=(g+1) mod NUM_REQ, go to LOOKUP.
- LOOKUP: drive the table with key_q. On the edge: rsp_value<=table(key_q), rsp_id<=id_q, rsp_valid<=1, go to RESP.
- RESP: hold rsp_valid, rsp_value and rsp_id stable. When rsp_ready=1: rsp_valid<=0, go to IDLE.
- req_ready=0 in LOOKUP and RESP.
- Latency: handshake at edge N, rsp_valid high after edge N+1. A new grant is possible at the edge after the rsp_ready handshake, so sustained throughput is one lookup per 3 cycles when rsp_ready is tied high.
- No back-to-back bypass: the cycle after acceptance is always IDLE.
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.
- rr_ptr advances only on a grant, never on idle cycles.
- Requester behaviour:
  - A requester may drop req_valid before its grant with no side effect.
  - Once req_valid is asserted it should hold key stable; the arbiter samples only at the handshake edge.
- rsp_ready outside RESP is ignored.
- Simultaneous requests from all requesters with rr_ptr=k: k wins, then k+1, and so on.
- rsp_value and rsp_id are registers and never glitch.
- Key values are fully decoded: every 4-bit key yields a defined value, so there is no X propagation.

Decomposition:
- Package lut_pkg:
  - localparams KEY_W=4, VAL_W=8.
  - typedef enum logic [1:0] {IDLE, LOOKUP, RESP} lut_state_t.
  - typedef logic [KEY_W-1:0] lut_key_t and logic [VAL_W-1:0] lut_val_t.
- Sub-modules:
  - Instantiate the existing table module lookup (key in, value out) unchanged.
  - Place the round-robin grant logic in sub-module rr_grant (inputs req, ptr; output one-hot grant), purely combinational.

Test Plan:
1. Reset and single request:
   - Stimulus: rst_n low for 2 cycles, then release; requester 0 sends key=4'h2, rsp_ready=1.
   - Required: req_ready=2'b01 in the same cycle; two edges later rsp_valid=1, rsp_value=8'h05, rsp_id=0; rsp_valid=0 the following cycle.
2. Simultaneous requests with rr_ptr=0:
   - Stimulus: req0 key=4'h0 and req1 key=4'h3, both held valid.
   - Required: grant order 0 then 1; responses (id0, 8'h01) then (id1, 8'h07); third grant goes to 0.
3. Backpressure:
   - Stimulus: key=4'h1, rsp_ready=0 for 5 cycles, then 1.
   - Required: rsp_valid, rsp_value=8'h03 and rsp_id held stable for all 5 cycles; req_ready=0 throughout; busy=1 until acceptance.
4. Upper keys:
   - Stimulus: sweep keys 4'h4..4'hF from requester 1.
   - Required: every rsp_value=8'hFF, rsp_id=1.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 asynchronously while in LOOKUP (between edges).
   - Required: rsp_valid=0, busy=0 immediately, no response ever issued for that key; after release, rr_ptr=0 so req0 wins over req1.
6. Fairness at NUM_REQ=3:
   - Stimulus: all three requesters held valid for 9 grants.
   - Required: grant sequence 0,1,2,0,1,2,0,1,2.
